// File: rtl/command_tx.sv
// command_tx: serialises one of four fixed AT-command strings onto a UART TX line,
// 8N1 LSB first; ready_command is low while a string is on the wire.
module command_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CMD_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] command,
    input  logic             start,
    output logic             ready_command,
    output logic             done,
    output logic             tx
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0] IDLE = 2'd0, START_BIT = 2'd1, DATA = 2'd2, STOP_BIT = 2'd3;

    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx, nxt_bit;
    logic [3:0] pos, len;
    logic [CMD_W-1:0] cmd;
    logic [103:0] str;
    logic [7:0] cur;

    // Strings are left-aligned in a 13-byte field, so byte pos is found by shifting right.
    always_comb begin
        str = cmd == CMD_W'(0) ? {32'h41540D0A, 72'h0} :
              cmd == CMD_W'(1) ? {64'h41542B5253540D0A, 40'h0} :
              cmd == CMD_W'(2) ? 104'h41542B43574D4F44453D310D0A :
                                 104'h41542B4349504D55583D310D0A;
        len = cmd == CMD_W'(0) ? 4'd4 : cmd == CMD_W'(1) ? 4'd8 : 4'd13;
        cur = 8'(str >> {4'd12 - pos, 3'b000});
        nxt_bit = bit_idx + 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            pos <= '0;
            cmd <= '0;
            tx <= 1'b1;
            ready_command <= 1'b1;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    cmd <= command;
                    pos <= '0;
                    cnt <= '0;
                    tx <= 1'b0;
                    ready_command <= 1'b0;
                    state <= START_BIT;
                end
            end else if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
                case (state)
                    START_BIT: begin
                        bit_idx <= '0;
                        tx <= cur[0];
                        state <= DATA;
                    end
                    DATA: begin
                        bit_idx <= nxt_bit;
                        tx <= bit_idx == 3'd7 ? 1'b1 : cur[nxt_bit];
                        state <= bit_idx == 3'd7 ? STOP_BIT : DATA;
                    end
                    STOP_BIT: begin
                        // Next byte's start bit follows the stop bit with no idle gap.
                        if (pos < len - 4'd1) begin
                            pos <= pos + 4'd1;
                            tx <= 1'b0;
                            state <= START_BIT;
                        end else begin
                            ready_command <= 1'b1;
                            done <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_command_tx.sv
// tb_command_tx: table-driven and randomized checks of command_tx against a
// frame-level model of the AT-command strings.
module tb_command_tx;
    localparam int CPB = 4;
    localparam int FRAME = 10 * CPB;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [1:0] command = 2'd0;
    logic ready_command, done, tx;
    int errors = 0, checks = 0;

    typedef struct {
        logic [1:0] cmd;
        int len;
        logic [103:0] str;
    } vec_t;
    vec_t vecs[4];

    command_tx #(.CLKS_PER_BIT(CPB), .CMD_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .command(command),
        .start(start),
        .ready_command(ready_command),
        .done(done),
        .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected line level k cycles after acceptance: start, 8 data bits LSB first, stop.
    function automatic logic frame_bit(input vec_t v, input int k);
        int b = k / FRAME;
        int s = (k % FRAME) / CPB;
        logic [7:0] by = v.str[103 - 8*b -: 8];
        return s == 0 ? 1'b0 : s == 9 ? 1'b1 : by[s-1];
    endfunction

    task automatic xfer(input logic [1:0] c, input logic hold, input int poke, input logic twiddle);
        logic q[$];
        int busy = 0;
        int mism = 0;
        vec_t v = vecs[c];
        logic [7:0] d;
        command = c;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        while (ready_command === 1'b0 && busy < 1000) begin
            q.push_back(tx);
            busy++;
            if (twiddle) command = 2'($urandom);
            if (busy == poke) begin
                start = 1'b1;
                command = 2'd3;
            end else if (!hold) start = 1'b0;
            @(negedge clk);
        end
        check($sformatf("busy cycles cmd%0d", c), busy, v.len * FRAME);
        for (int k = 0; k < v.len * FRAME; k++)
            if (k >= q.size() || q[k] !== frame_bit(v, k)) mism++;
        check($sformatf("waveform mismatches cmd%0d", c), mism, 0);
        if (q.size() >= v.len * FRAME)
            for (int j = 0; j < v.len; j++) begin
                for (int i = 0; i < 8; i++) d[i] = q[j*FRAME + CPB*(i+1) + CPB/2];
                check($sformatf("byte cmd%0d pos%0d", c, j), d, v.str[103 - 8*j -: 8]);
            end
        check("ready/done/tx at end", {ready_command, done, tx}, 3'b111);
        if (!hold) begin
            @(negedge clk);
            check("ready/done/tx after done", {ready_command, done, tx}, 3'b101);
        end
    endtask

    task automatic idle_check(input string name, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (ready_command !== 1'b1 || tx !== 1'b1 || done !== 1'b0) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        vecs[0] = '{2'd0, 4, {32'h41540D0A, 72'h0}};
        vecs[1] = '{2'd1, 8, {64'h41542B5253540D0A, 40'h0}};
        vecs[2] = '{2'd2, 13, 104'h41542B43574D4F44453D310D0A};
        vecs[3] = '{2'd3, 13, 104'h41542B4349504D55583D310D0A};

        repeat (5) @(negedge clk);
        check("reset state", {ready_command, done, tx}, 3'b101);
        rst = 1'b1;
        idle_check("idle without start", 100);

        for (int i = 0; i < 4; i++) xfer(vecs[i].cmd, 1'b0, -1, 1'b0);

        xfer(2'd1, 1'b0, 50, 1'b0);
        idle_check("dropped start not queued", 100);

        xfer(2'd0, 1'b1, -1, 1'b0);
        xfer(2'd0, 1'b1, -1, 1'b0);
        xfer(2'd0, 1'b0, -1, 1'b0);

        command = 2'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (69) @(negedge clk);
        check("busy before reset", ready_command, 1'b0);
        #2 rst = 1'b0;
        #1 check("async reset mid-transfer", {ready_command, done, tx}, 3'b101);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        xfer(2'd0, 1'b0, -1, 1'b0);

        for (int n = 0; n < 20; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            xfer(2'($urandom), 1'b0, $urandom_range(0, 1) ? int'($urandom_range(1, 30)) : -1,
                 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
